tod_counter: RTL and testbench

TOD_COUNTER -- requirements
Module: tod_counter

---
 rtl/tod_pkg.sv | 23 ++
 rtl/tod_counter_mod_counter.sv | 53 +++++
 rtl/tod_counter.sv | 195 +++++++++++++++++++
 tb/tb_tod_counter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tod_pkg.sv
// Shared constants for the time-of-day counter: field-select codes and the
// alarm state encoding used when TOD_ALARM_EN is defined.
package tod_pkg;

  // Field select codes driven on i_sel
  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HR   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Alarm FSM state type and encodings
  typedef logic [1:0] alarm_state_t;

  localparam alarm_state_t ALM_IDLE  = 2'd0;
  localparam alarm_state_t ALM_RING  = 2'd1;
  localparam alarm_state_t ALM_ACKED = 2'd2;

  // True when the given select code addresses a real field
  function automatic logic sel_is_field(input logic [1:0] sel);
    return sel != SEL_NONE;
  endfunction

endpackage

// File: rtl/tod_counter_mod_counter.sv
// Modulo-(MAX+1) up/down counter used for each time field. o_wrap flags a
// MAX->0 step this cycle and feeds the next field's carry combinationally.
module mod_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_srst,
  input  logic         i_en_up,
  input  logic         i_en_dn,
  output logic [W-1:0] o_value,
  output logic         o_wrap
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] value_q, value_d;
  logic         step_up, step_dn;

  // Up and down together cancel out
  assign step_up = i_en_up & ~i_en_dn;
  assign step_dn = i_en_dn & ~i_en_up;

  // Next value: clear has priority, then a single wrapping step
  always_comb begin
    value_d = value_q;
    if (i_srst) begin
      value_d = '0;
    end else if (step_up) begin
      value_d = (value_q == MaxVal) ? '0 : value_q + 1'b1;
    end else if (step_dn) begin
      value_d = (value_q == '0) ? MaxVal : value_q - 1'b1;
    end
  end

  // Field register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Combinational wrap for carry into the next field
  always_comb begin
    o_wrap = step_up & (value_q == MaxVal);
  end

  assign o_value = value_q;

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: hh:mm:ss with a combinational carry chain, set mode
// for per-field adjustment, and registered wrap pulses.
// Optional alarm (hr/min compare, IDLE/RING/ACKED FSM) under TOD_ALARM_EN.
module tod_counter
  import tod_pkg::*;
#(
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned HR_MAX  = 23,
  parameter int unsigned SEC_W   = 6,
  parameter int unsigned MIN_W   = 6,
  parameter int unsigned HR_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_srst,
  input  logic             i_tick,
  input  logic             i_set_en,
  input  logic [1:0]       i_sel,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_alarm_we,
  input  logic [MIN_W-1:0] i_alarm_min,
  input  logic [HR_W-1:0]  i_alarm_hr,
  input  logic             i_alarm_on,
  input  logic             i_alarm_ack,
  output logic [SEC_W-1:0] o_sec,
  output logic [MIN_W-1:0] o_min,
  output logic [HR_W-1:0]  o_hr,
  output logic             o_min_tick,
  output logic             o_hr_tick,
  output logic             o_day_tick,
  output logic             o_alarm
);

  logic run_tick;
  logic adj_up, adj_dn;
  logic sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn;
  logic sec_wrap, min_wrap, hr_wrap;
  logic sec_carry, min_carry, hr_carry;

  logic min_tick_q, min_tick_d;
  logic hr_tick_q, hr_tick_d;
  logic day_tick_q, day_tick_d;

  // Decode run-mode ticks and set-mode adjust requests
  always_comb begin
    run_tick = ~i_set_en & i_tick;
    adj_up   = i_set_en & i_inc & ~i_dec & sel_is_field(i_sel);
    adj_dn   = i_set_en & i_dec & ~i_inc & sel_is_field(i_sel);
  end

  // Per-field enables; carries only ever originate from a run-mode tick
  always_comb begin
    sec_up    = run_tick | (adj_up & (i_sel == SEL_SEC));
    sec_dn    = adj_dn & (i_sel == SEL_SEC);
    sec_carry = run_tick & sec_wrap;

    min_up    = sec_carry | (adj_up & (i_sel == SEL_MIN));
    min_dn    = adj_dn & (i_sel == SEL_MIN);
    min_carry = sec_carry & min_wrap;

    hr_up     = min_carry | (adj_up & (i_sel == SEL_HR));
    hr_dn     = adj_dn & (i_sel == SEL_HR);
    hr_carry  = min_carry & hr_wrap;
  end

  mod_counter #(
    .MAX (SEC_MAX),
    .W   (SEC_W)
  ) u_sec (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_srst  (i_srst),
    .i_en_up (sec_up),
    .i_en_dn (sec_dn),
    .o_value (o_sec),
    .o_wrap  (sec_wrap)
  );

  mod_counter #(
    .MAX (MIN_MAX),
    .W   (MIN_W)
  ) u_min (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_srst  (i_srst),
    .i_en_up (min_up),
    .i_en_dn (min_dn),
    .o_value (o_min),
    .o_wrap  (min_wrap)
  );

  mod_counter #(
    .MAX (HR_MAX),
    .W   (HR_W)
  ) u_hr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_srst  (i_srst),
    .i_en_up (hr_up),
    .i_en_dn (hr_dn),
    .o_value (o_hr),
    .o_wrap  (hr_wrap)
  );

  // Wrap pulses follow the carries, suppressed by synchronous clear
  always_comb begin
    min_tick_d = sec_carry & ~i_srst;
    hr_tick_d  = min_carry & ~i_srst;
    day_tick_d = hr_carry & ~i_srst;
  end

  // Wrap pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min_tick_q <= 1'b0;
      hr_tick_q  <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      min_tick_q <= min_tick_d;
      hr_tick_q  <= hr_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign o_min_tick = min_tick_q;
  assign o_hr_tick  = hr_tick_q;
  assign o_day_tick = day_tick_q;

`ifdef TOD_ALARM_EN
  logic [MIN_W-1:0] alarm_min_q, alarm_min_d;
  logic [HR_W-1:0]  alarm_hr_q, alarm_hr_d;
  alarm_state_t     state_q, state_d;
  logic             hm_match;

  // Alarm time load
  always_comb begin
    alarm_min_d = alarm_min_q;
    alarm_hr_d  = alarm_hr_q;
    if (i_alarm_we) begin
      alarm_min_d = i_alarm_min;
      alarm_hr_d  = i_alarm_hr;
    end
  end

  // Alarm FSM next state; the compare uses the registered time
  always_comb begin
    hm_match = (o_hr == alarm_hr_q) && (o_min == alarm_min_q);
    state_d  = state_q;
    case (state_q)
      ALM_IDLE: begin
        if (i_alarm_on && hm_match && (o_sec == '0)) begin
          state_d = ALM_RING;
        end
      end
      ALM_RING: begin
        if (!i_alarm_on) begin
          state_d = ALM_IDLE;
        end else if (i_alarm_ack) begin
          state_d = ALM_ACKED;
        end
      end
      ALM_ACKED: begin
        // Hold off re-ringing until the matching minute has passed
        if (!hm_match) begin
          state_d = ALM_IDLE;
        end
      end
      default: state_d = ALM_IDLE;
    endcase
  end

  // Alarm registers and FSM state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alarm_min_q <= '0;
      alarm_hr_q  <= '0;
      state_q     <= ALM_IDLE;
    end else begin
      alarm_min_q <= alarm_min_d;
      alarm_hr_q  <= alarm_hr_d;
      state_q     <= state_d;
    end
  end

  assign o_alarm = (state_q == ALM_RING);
`else
  // Alarm compiled out: inputs are accepted but have no effect
  logic unused_alarm;
  assign unused_alarm = ^{i_alarm_we, i_alarm_min, i_alarm_hr, i_alarm_on, i_alarm_ack};
  assign o_alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Self-checking bench for tod_counter: a field-level time model checked every
// cycle, plus directed literal checks around the wrap and alarm scenarios.
module tb_tod_counter;

`ifdef TOD_ALARM_EN
  localparam int ALM = 1;
`else
  localparam int ALM = 0;
`endif

  logic       i_clk;
  logic       i_rst_n;
  logic       i_srst;
  logic       i_tick;
  logic       i_set_en;
  logic [1:0] i_sel;
  logic       i_inc;
  logic       i_dec;
  logic       i_alarm_we;
  logic [5:0] i_alarm_min;
  logic [4:0] i_alarm_hr;
  logic       i_alarm_on;
  logic       i_alarm_ack;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hr;
  logic       o_min_tick;
  logic       o_hr_tick;
  logic       o_day_tick;
  logic       o_alarm;

  int total = 0;
  int bad   = 0;

  tod_counter dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_srst      (i_srst),
    .i_tick      (i_tick),
    .i_set_en    (i_set_en),
    .i_sel       (i_sel),
    .i_inc       (i_inc),
    .i_dec       (i_dec),
    .i_alarm_we  (i_alarm_we),
    .i_alarm_min (i_alarm_min),
    .i_alarm_hr  (i_alarm_hr),
    .i_alarm_on  (i_alarm_on),
    .i_alarm_ack (i_alarm_ack),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hr        (o_hr),
    .o_min_tick  (o_min_tick),
    .o_hr_tick   (o_hr_tick),
    .o_day_tick  (o_day_tick),
    .o_alarm     (o_alarm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time as three plain integer fields
  int ms, mm, mh, mmt, mht, mdt, alm_m, alm_h, ast;
  int s, m, h, d, mt, ht, dt;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ms <= 0; mm <= 0; mh <= 0; mmt <= 0; mht <= 0; mdt <= 0;
      alm_m <= 0; alm_h <= 0; ast <= 0;
    end else begin
      s = ms; m = mm; h = mh; mt = 0; ht = 0; dt = 0;
      if (i_srst) begin
        s = 0; m = 0; h = 0;
      end else if (!i_set_en && i_tick) begin
        s = (s + 1) % 60;
        if (s == 0) begin
          mt = 1;
          m  = (m + 1) % 60;
          if (m == 0) begin
            ht = 1;
            h  = (h + 1) % 24;
            if (h == 0) dt = 1;
          end
        end
      end else if (i_set_en && (i_inc != i_dec)) begin
        d = i_inc ? 1 : -1;
        case (i_sel)
          2'd0: s = (s + d + 60) % 60;
          2'd1: m = (m + d + 60) % 60;
          2'd2: h = (h + d + 24) % 24;
          default: ;
        endcase
      end
      if (ALM == 1) begin
        if (i_alarm_we) begin
          alm_m <= int'(i_alarm_min);
          alm_h <= int'(i_alarm_hr);
        end
        // 0 = idle, 1 = ringing, 2 = acknowledged
        if (ast == 0 && i_alarm_on && mh == alm_h && mm == alm_m && ms == 0) ast <= 1;
        else if (ast == 1 && !i_alarm_on) ast <= 0;
        else if (ast == 1 && i_alarm_ack) ast <= 2;
        else if (ast == 2 && !(mh == alm_h && mm == alm_m)) ast <= 0;
      end
      ms <= s; mm <= m; mh <= h; mmt <= mt; mht <= ht; mdt <= dt;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge i_clk) begin
    check("sec", int'(o_sec), ms);
    check("min", int'(o_min), mm);
    check("hr", int'(o_hr), mh);
    check("min_tick", int'(o_min_tick), mmt);
    check("hr_tick", int'(o_hr_tick), mht);
    check("day_tick", int'(o_day_tick), mdt);
    check("alarm", int'(o_alarm), (ast == 1) ? 1 : 0);
  end

  // One clock edge; inputs set before the call are sampled on it
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
    end
  endtask

  task automatic adj(input logic [1:0] sel, input logic inc, input logic dec, input int n);
    i_set_en = 1'b1;
    i_sel    = sel;
    for (int i = 0; i < n; i++) begin
      i_inc = inc;
      i_dec = dec;
      step();
      i_inc = 1'b0;
      i_dec = 1'b0;
    end
    i_set_en = 1'b0;
  endtask

  task automatic clear();
    i_srst = 1'b1;
    step();
    i_srst = 1'b0;
  endtask

  task automatic check_time(input string nm, input int hh, input int mi, input int ss);
    check({nm, ".hr"}, int'(o_hr), hh);
    check({nm, ".min"}, int'(o_min), mi);
    check({nm, ".sec"}, int'(o_sec), ss);
  endtask

  task automatic check_ticks(input string nm, input int a, input int b, input int c);
    check({nm, ".min_tick"}, int'(o_min_tick), a);
    check({nm, ".hr_tick"}, int'(o_hr_tick), b);
    check({nm, ".day_tick"}, int'(o_day_tick), c);
  endtask

  task automatic write_alarm(input int hh, input int mi);
    i_alarm_we  = 1'b1;
    i_alarm_hr  = 5'(hh);
    i_alarm_min = 6'(mi);
    i_alarm_on  = 1'b1;
    step();
    i_alarm_we  = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_srst = 1'b0; i_tick = 1'b0; i_set_en = 1'b0; i_sel = 2'd0;
    i_inc = 1'b0; i_dec = 1'b0; i_alarm_we = 1'b0; i_alarm_min = '0; i_alarm_hr = '0;
    i_alarm_on = 1'b0; i_alarm_ack = 1'b0;

    #3;
    check_time("reset", 0, 0, 0);
    check_ticks("reset", 0, 0, 0);
    check("reset.alarm", int'(o_alarm), 0);
    step();
    i_rst_n = 1'b1;
    step();
    check_time("post_reset", 0, 0, 0);

    // 00:00:58 + two ticks -> 00:01:00 with a single minute pulse
    clear();
    adj(2'd0, 1'b0, 1'b1, 2);
    check_time("preload58", 0, 0, 58);
    ticks(1);
    check_time("t59", 0, 0, 59);
    check_ticks("t59", 0, 0, 0);
    ticks(1);
    check_time("t60", 0, 1, 0);
    check_ticks("t60", 1, 0, 0);
    step();
    check_ticks("t60_after", 0, 0, 0);

    // 23:59:59 + tick -> midnight, all pulses together
    clear();
    adj(2'd0, 1'b0, 1'b1, 1);
    adj(2'd1, 1'b0, 1'b1, 1);
    adj(2'd2, 1'b0, 1'b1, 1);
    check_time("preload_eod", 23, 59, 59);
    ticks(1);
    check_time("midnight", 0, 0, 0);
    check_ticks("midnight", 1, 1, 1);
    step();
    check_ticks("midnight_after", 0, 0, 0);

    // Set mode: min 0 -> 59 by decrement, no carry, ticks ignored
    clear();
    adj(2'd1, 1'b0, 1'b1, 1);
    check_time("set_dec_min", 0, 59, 0);
    check_ticks("set_dec_min", 0, 0, 0);
    i_set_en = 1'b1;
    ticks(3);
    check_time("set_ticks_ignored", 0, 59, 0);
    i_set_en = 1'b0;
    adj(2'd2, 1'b1, 1'b1, 2);
    adj(2'd3, 1'b1, 1'b0, 2);
    check_time("set_noop", 0, 59, 0);
    adj(2'd1, 1'b1, 1'b0, 1);
    check_time("set_inc_wrap", 0, 0, 0);
    check_ticks("set_inc_wrap", 0, 0, 0);
    i_inc = 1'b1;
    step();
    i_inc = 1'b0;
    check_time("run_inc_ignored", 0, 0, 0);

    // Synchronous clear beats a simultaneous tick at 12:34:56
    adj(2'd2, 1'b1, 1'b0, 12);
    adj(2'd1, 1'b1, 1'b0, 34);
    adj(2'd0, 1'b0, 1'b1, 4);
    check_time("preload_1234", 12, 34, 56);
    i_srst = 1'b1; i_tick = 1'b1;
    step();
    i_srst = 1'b0; i_tick = 1'b0;
    check_time("srst_tick", 0, 0, 0);
    check_ticks("srst_tick", 0, 0, 0);
    // Clear also suppresses a pulse that the tick would have produced
    adj(2'd0, 1'b0, 1'b1, 1);
    adj(2'd1, 1'b0, 1'b1, 1);
    adj(2'd2, 1'b0, 1'b1, 1);
    i_srst = 1'b1; i_tick = 1'b1;
    step();
    i_srst = 1'b0; i_tick = 1'b0;
    check_time("srst_eod", 0, 0, 0);
    check_ticks("srst_eod", 0, 0, 0);

    // Alarm at 07:30: ring, acknowledge, no re-ring through the minute
    clear();
    adj(2'd2, 1'b1, 1'b0, 7);
    adj(2'd1, 1'b1, 1'b0, 29);
    adj(2'd0, 1'b0, 1'b1, 1);
    write_alarm(7, 30);
    check_time("alarm_pre", 7, 29, 59);
    ticks(1);
    check_time("alarm_hit", 7, 30, 0);
    check("alarm_hit.alarm", int'(o_alarm), 0);
    step();
    check("alarm_ring", int'(o_alarm), ALM);
    i_alarm_ack = 1'b1;
    step();
    i_alarm_ack = 1'b0;
    check("alarm_acked", int'(o_alarm), 0);
    ticks(59);
    check_time("alarm_5959", 7, 30, 59);
    check("alarm_no_rering", int'(o_alarm), 0);
    ticks(1);
    step();
    check_time("alarm_0731", 7, 31, 0);
    check("alarm_0731.alarm", int'(o_alarm), 0);

    // Async reset mid-count at 05:06:07 while ringing
    clear();
    adj(2'd2, 1'b1, 1'b0, 5);
    adj(2'd1, 1'b1, 1'b0, 5);
    adj(2'd0, 1'b0, 1'b1, 1);
    write_alarm(5, 6);
    ticks(1);
    step();
    ticks(7);
    check_time("pre_rst", 5, 6, 7);
    check("pre_rst.alarm", int'(o_alarm), ALM);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_time("async_rst", 0, 0, 0);
    check_ticks("async_rst", 0, 0, 0);
    check("async_rst.alarm", int'(o_alarm), 0);
    step();
    i_rst_n = 1'b1;
    i_alarm_on = 1'b0;
    ticks(2);
    check_time("after_rst", 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
